fx_dot_accum: RTL

//  Streaming fixed-point accumulator directly downstream of the constant multipliers.

---
 rtl/fx_pkg.sv | 17 +
 rtl/fx_sat.sv | 35 +++
 rtl/fx_dot_accum.sv | 118 +++++++++++
 3 files changed

// File: rtl/fx_pkg.sv
// Shared Q-format constants, FSM state type and saturation limits for the
// fixed-point datapath blocks (default build wraps; see FX_DOT_ACCUM_SATURATE_EN).
package fx_pkg;

    localparam int FX_WIDTH        = 32;
    localparam int FX_DECIMAL_BITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } fx_state_e;

    localparam logic [FX_WIDTH-1:0] FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
    localparam logic [FX_WIDTH-1:0] FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fx_sat.sv
// Narrows a wide signed sum to WIDTH bits and flags overflow.
// FX_DOT_ACCUM_SATURATE_EN clamps on overflow; otherwise the low bits wrap.
module fx_sat
    import fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int ACC_W = FX_WIDTH + 4
) (
    input  logic [ACC_W-1:0] sum_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // The value fits only when every bit above the result's sign bit equals it.
    logic [ACC_W-WIDTH:0] top_s;
    assign top_s = sum_i[ACC_W-1:WIDTH-1];

    // Range check and output narrowing.
    always_comb begin
        ovf_o = ~((&top_s) | ~(|top_s));
`ifdef FX_DOT_ACCUM_SATURATE_EN
        if (ovf_o) begin
            data_o = sum_i[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            data_o = sum_i[WIDTH-1:0];
        end
`else
        data_o = sum_i[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/fx_dot_accum.sv
// Streaming row accumulator: sums N_TERMS signed fixed-point products per row and
// emits one WIDTH-bit result with overflow flag. Optional FX_DOT_ACCUM_SATURATE_EN.
module fx_dot_accum
    import fx_pkg::*;
#(
    parameter int WIDTH        = FX_WIDTH,
    parameter int DECIMAL_BITS = FX_DECIMAL_BITS,
    parameter int N_TERMS      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int ACC_W = WIDTH + $clog2(N_TERMS) + 1;
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    if (DECIMAL_BITS >= WIDTH || N_TERMS < 1) begin : g_bad_cfg
        $error("fx_dot_accum: invalid DECIMAL_BITS/N_TERMS");
    end

    fx_state_e        state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] sext_s;
    logic [ACC_W-1:0] sum_s;
    logic [WIDTH-1:0] sat_data_s;
    logic             sat_ovf_s;
    logic             accept_s;
    logic             last_s;

    // A beat taken in IDLE or OUT is term 0 of a new row, so it replaces the sum.
    assign sext_s   = {{(ACC_W-WIDTH){in_data[WIDTH-1]}}, in_data};
    assign sum_s    = (state_q == ACC) ? (acc_q + sext_s) : sext_s;
    assign in_ready = rst_n & ~clear & ((state_q != OUT) | out_ready);
    assign accept_s = in_valid & in_ready;
    assign last_s   = (state_q == ACC) ? (cnt_q == LAST_CNT) : (N_TERMS == 1);

    fx_sat #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_sat (
        .sum_i  (sum_s),
        .data_o (sat_data_s),
        .ovf_o  (sat_ovf_s)
    );

    // Next-state logic for the row FSM, accumulator, term counter and result.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            acc_d = sum_s;
            cnt_d = (state_q == ACC) ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
            if (last_s) begin
                state_d     = OUT;
                out_valid_d = 1'b1;
                out_data_d  = sat_data_s;
                out_ovf_d   = sat_ovf_s;
            end else begin
                state_d     = ACC;
                out_valid_d = 1'b0;
            end
        end else if ((state_q == OUT) && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (state_q != IDLE);

endmodule
